// File: rtl/mult_pipe_unit.sv
// -----------------------------------------------------------------------------
// mult_pipe_unit
//
// Pipelined integer multiplier for the EX stage. Operands are captured into
// stage 1, the product is formed from the stage-1 registers and then carried
// down the remaining stages. On leaving the last stage the {rd, product} pair
// is pushed into a small writeback FIFO. The FIFO drains whenever the
// register-file write port is granted to this unit.
//
// Optional feature macro: MULT_HI_EN
//   defined   : the full 2*DATA_WIDTH product is carried and stored, and the
//               upper half is exported on o_wb_data_hi. i_signed selects
//               signed/unsigned extension.
//   undefined : only the low half is computed and stored. The low half is the
//               same for signed and unsigned operands, so i_signed has no
//               visible effect.
//
// Handshake: an issue is accepted on a rising edge where i_valid && o_ready.
// o_ready is derived from registered state only (in-flight stages plus
// buffered entries below WB_DEPTH), so it never depends on i_valid or
// i_wb_grant. A writeback pops on a rising edge where o_wb_valid &&
// i_wb_grant; i_wb_grant is ignored while o_wb_valid is low.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid / o_ready       issue handshake
//   i_signed, i_a, i_b      operation type and operands
//   i_rd                    destination register of the issue
//   i_rs, i_rt              ID-stage source registers to check for hazards
//   o_hazard_rs/_rt         source matches a pending destination (rd != 0)
//   o_wb_valid, o_wb_rd,
//   o_wb_data               FIFO head (rd and data read as zero when empty)
//   o_wb_data_hi            upper product half (MULT_HI_EN only)
//   i_wb_grant              write port granted this cycle
//   o_busy                  any stage or FIFO entry valid
// -----------------------------------------------------------------------------
module mult_pipe_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 3,
  parameter int WB_DEPTH   = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_signed,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rt,
  output logic                  o_hazard_rs,
  output logic                  o_hazard_rt,
  output logic                  o_wb_valid,
  output logic [REG_ADDR_W-1:0] o_wb_rd,
  output logic [DATA_WIDTH-1:0] o_wb_data,
`ifdef MULT_HI_EN
  output logic [DATA_WIDTH-1:0] o_wb_data_hi,
`endif
  input  logic                  i_wb_grant,
  output logic                  o_busy
);

  localparam int W = DATA_WIDTH;
`ifdef MULT_HI_EN
  localparam int PW = 2 * W;
`else
  localparam int PW = W;
`endif
  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH + 1);
  localparam int SUM_W = $clog2(STAGES + WB_DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Stage control: bit k of r_stg_vld / entry k of r_stg_rd is stage k+1.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0]     r_stg_vld;
  logic [REG_ADDR_W-1:0] r_stg_rd [STAGES];
  logic [W-1:0]          r_s1_a;
  logic [W-1:0]          r_s1_b;
  logic                  r_s1_sgn;

  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_wb_valid;
  logic [PW-1:0]         w_prod;
  logic [PW-1:0]         w_out_prod;

  assign w_issue = i_valid & o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stg_vld <= '0;
    end else begin
      r_stg_vld[0] <= w_issue;
      for (int k = 1; k < STAGES; k++) begin
        r_stg_vld[k] <= r_stg_vld[k-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_issue) begin
      r_s1_a      <= i_a;
      r_s1_b      <= i_b;
      r_s1_sgn    <= i_signed;
      r_stg_rd[0] <= i_rd;
    end
    for (int k = 1; k < STAGES; k++) begin
      r_stg_rd[k] <= r_stg_rd[k-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Product formed from the stage-1 operands.
  // ---------------------------------------------------------------------------
`ifdef MULT_HI_EN
  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_b_ext;

  // Sign- or zero-extend to 2W; a 2W-bit modular product of the extended
  // operands is the exact signed or unsigned 2W-bit result.
  always_comb begin
    w_a_ext = {{W{r_s1_sgn & r_s1_a[W-1]}}, r_s1_a};
    w_b_ext = {{W{r_s1_sgn & r_s1_b[W-1]}}, r_s1_b};
    w_prod  = w_a_ext * w_b_ext;
  end
`else
  // Both arms give identical low halves; the select merges away in synthesis.
  always_comb begin
    if (r_s1_sgn) w_prod = W'($signed(r_s1_a) * $signed(r_s1_b));
    else          w_prod = r_s1_a * r_s1_b;
  end
`endif

  // Stages 2..STAGES carry the finished product.
  generate
    if (STAGES > 1) begin : g_prod_pipe
      logic [PW-1:0] r_prod [1:STAGES-1];
      always_ff @(posedge i_clk) begin
        r_prod[1] <= w_prod;
        for (int k = 2; k < STAGES; k++) begin
          r_prod[k] <= r_prod[k-1];
        end
      end
      assign w_out_prod = r_prod[STAGES-1];
    end else begin : g_prod_comb
      assign w_out_prod = w_prod;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Writeback FIFO
  // ---------------------------------------------------------------------------
  logic [REG_ADDR_W-1:0] r_fifo_rd   [WB_DEPTH];
  logic [PW-1:0]         r_fifo_data [WB_DEPTH];
  logic [WB_DEPTH-1:0]   r_fifo_vld;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(WB_DEPTH - 1)) return '0;
    else                           return p + 1'b1;
  endfunction

  assign w_wb_valid = (r_cnt != '0);
  assign w_push     = r_stg_vld[STAGES-1];
  // Pop only acts on an entry already at the head, so a push into an empty
  // FIFO is never consumed by a same-cycle grant.
  assign w_pop      = w_wb_valid & i_wb_grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_fifo_vld <= '0;
    end else begin
      // Clear before set: when full, push and pop share one slot and the
      // incoming entry must win.
      if (w_pop) begin
        r_fifo_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr             <= ptr_inc(r_rd_ptr);
      end
      if (w_push) begin
        r_fifo_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr             <= ptr_inc(r_wr_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= r_stg_rd[STAGES-1];
      r_fifo_data[r_wr_ptr] <= w_out_prod;
    end
  end

  // ---------------------------------------------------------------------------
  // Credits: every in-flight stage already owns a FIFO slot, so occupancy is
  // stages plus buffered entries. A same-cycle pop is deliberately not
  // credited, which keeps o_ready independent of i_wb_grant.
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] w_occ;

  always_comb begin
    w_occ = SUM_W'(r_cnt);
    for (int k = 0; k < STAGES; k++) begin
      w_occ = w_occ + SUM_W'(r_stg_vld[k]);
    end
  end

  assign o_ready = (w_occ < SUM_W'(WB_DEPTH));

  // ---------------------------------------------------------------------------
  // Hazard query: register 0 is never a hazard.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_hazard_rs = 1'b0;
    o_hazard_rt = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (r_stg_vld[k] && (r_stg_rd[k] == i_rs)) o_hazard_rs = 1'b1;
      if (r_stg_vld[k] && (r_stg_rd[k] == i_rt)) o_hazard_rt = 1'b1;
    end
    for (int e = 0; e < WB_DEPTH; e++) begin
      if (r_fifo_vld[e] && (r_fifo_rd[e] == i_rs)) o_hazard_rs = 1'b1;
      if (r_fifo_vld[e] && (r_fifo_rd[e] == i_rt)) o_hazard_rt = 1'b1;
    end
    if (i_rs == '0) o_hazard_rs = 1'b0;
    if (i_rt == '0) o_hazard_rt = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Outputs: head fields are masked when empty so unreset storage never leaks.
  // ---------------------------------------------------------------------------
  assign o_wb_valid = w_wb_valid;
  assign o_wb_rd    = w_wb_valid ? r_fifo_rd[r_rd_ptr] : '0;
  assign o_wb_data  = w_wb_valid ? r_fifo_data[r_rd_ptr][W-1:0] : '0;
`ifdef MULT_HI_EN
  assign o_wb_data_hi = w_wb_valid ? r_fifo_data[r_rd_ptr][PW-1:W] : '0;
`endif
  assign o_busy     = (|r_stg_vld) | w_wb_valid;

endmodule

// File: tb/tb_mult_pipe_unit.sv
module tb_mult_pipe_unit;

  localparam int W  = 32;
  localparam int RW = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          sgn;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [RW-1:0] rd;
  logic [RW-1:0] rs;
  logic [RW-1:0] rt;
  logic          grant;

  logic          o_ready;
  logic          o_hazard_rs;
  logic          o_hazard_rt;
  logic          o_wb_valid;
  logic [RW-1:0] o_wb_rd;
  logic [W-1:0]  o_wb_data;
`ifdef MULT_HI_EN
  logic [W-1:0]  o_wb_data_hi;
`endif
  logic          o_busy;

  always #5 clk = ~clk;

  mult_pipe_unit #(
    .DATA_WIDTH(W), .STAGES(3), .WB_DEPTH(4), .REG_ADDR_W(RW)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_valid(valid), .o_ready(o_ready),
    .i_signed(sgn), .i_a(a), .i_b(b), .i_rd(rd),
    .i_rs(rs), .i_rt(rt),
    .o_hazard_rs(o_hazard_rs), .o_hazard_rt(o_hazard_rt),
    .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
`ifdef MULT_HI_EN
    .o_wb_data_hi(o_wb_data_hi),
`endif
    .i_wb_grant(grant), .o_busy(o_busy)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard entries are {rd, low product}.
  logic [RW+W-1:0] exp_q[$];

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one issue request; acceptance happens on the next edge if o_ready.
  task automatic drive_issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic is, input logic [RW-1:0] ird);
    valid = 1'b1;
    a     = ia;
    b     = ib;
    sgn   = is;
    rd    = ird;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; grant = 1'b0; sgn = 1'b0;
    a = '0; b = '0; rd = 5'd5; rs = 5'd5; rt = 5'd5;
    step(); step();
    rst = 1'b0;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", o_ready); end
    total++; if (o_hazard_rs !== 1'b0) begin bad++; $display("FAIL reset_haz_rs got=%0b want=0", o_hazard_rs); end
    total++; if (o_hazard_rt !== 1'b0) begin bad++; $display("FAIL reset_haz_rt got=%0b want=0", o_hazard_rt); end
    total++; if (o_wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%0b want=0", o_wb_valid); end
    total++; if (o_wb_rd !== 5'd0) begin bad++; $display("FAIL reset_wb_rd got=%0d want=0", o_wb_rd); end
    total++; if (o_wb_data !== 32'd0) begin bad++; $display("FAIL reset_wb_data got=%0h want=0", o_wb_data); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", o_busy); end
    rs = '0; rt = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single();
    grant = 1'b1;
    drive_issue(32'd7, 32'd6, 1'b0, 5'd9);
    step();                     // edge 0: accept
    valid = 1'b0;
    for (int e = 0; e < 3; e++) begin
      total++; if (o_wb_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid edge=%0d got=%0b want=0", e, o_wb_valid); end
      step();
    end
    // just after edge 3
    total++; if (o_wb_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", o_wb_valid); end
    total++; if (o_wb_rd !== 5'd9) begin bad++; $display("FAIL single_rd got=%0d want=9", o_wb_rd); end
    total++; if (o_wb_data !== 32'd42) begin bad++; $display("FAIL single_data got=%0d want=42", o_wb_data); end
    step();                     // edge 4: pop
    total++; if (o_wb_valid !== 1'b0) begin bad++; $display("FAIL single_popped got=%0b want=0", o_wb_valid); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%0b want=0", o_busy); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_signed(input logic is, input logic [W-1:0] want_hi);
    grant = 1'b1;
    drive_issue(32'hFFFF_FFFF, 32'd2, is, 5'd3);
    step();
    valid = 1'b0;
    step(); step(); step();
    total++; if (o_wb_data !== 32'hFFFF_FFFE) begin bad++; $display("FAIL signed_lo sgn=%0b got=%0h want=fffffffe", is, o_wb_data); end
`ifdef MULT_HI_EN
    total++; if (o_wb_data_hi !== want_hi) begin bad++; $display("FAIL signed_hi sgn=%0b got=%0h want=%0h", is, o_wb_data_hi, want_hi); end
`else
    if (want_hi == 32'hFFFF_FFFF) begin end  // upper half not present in this build
`endif
    step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    grant = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_pre i=%0d got=%0b want=1", i, o_ready); end
      drive_issue(32'(i), 32'd10, 1'b0, RW'(i));
      step();
    end
    valid = 1'b0;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_drop got=%0b want=0", o_ready); end
    step(); step(); step();     // FIFO now holds all four
    total++; if (o_wb_valid !== 1'b1) begin bad++; $display("FAIL b2b_full_valid got=%0b want=1", o_wb_valid); end
    total++; if (o_wb_rd !== 5'd1) begin bad++; $display("FAIL b2b_head_rd got=%0d want=1", o_wb_rd); end
    total++; if (o_wb_data !== 32'd10) begin bad++; $display("FAIL b2b_head_data got=%0d want=10", o_wb_data); end
    step(); step();             // hold with grant low
    total++; if (o_wb_rd !== 5'd1) begin bad++; $display("FAIL b2b_hold_rd got=%0d want=1", o_wb_rd); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL b2b_hold_ready got=%0b want=0", o_ready); end
    grant = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      step();
      total++; if (o_wb_rd !== RW'(i)) begin bad++; $display("FAIL b2b_pop_rd got=%0d want=%0d", o_wb_rd, i); end
      total++; if (o_wb_data !== 32'(i * 10)) begin bad++; $display("FAIL b2b_pop_data got=%0d want=%0d", o_wb_data, i * 10); end
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_back got=%0b want=1", o_ready); end
    end
    step();
    total++; if (o_wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%0b want=0", o_wb_valid); end
    grant = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_hazard();
    grant = 1'b1; rs = 5'd5; rt = 5'd0;
    total++; if (o_hazard_rs !== 1'b0) begin bad++; $display("FAIL haz_pre got=%0b want=0", o_hazard_rs); end
    drive_issue(32'd1, 32'd1, 1'b0, 5'd5);
    step();
    valid = 1'b0;
    for (int e = 0; e < 4; e++) begin
      total++; if (o_hazard_rs !== 1'b1) begin bad++; $display("FAIL haz_rs edge=%0d got=%0b want=1", e, o_hazard_rs); end
      total++; if (o_hazard_rt !== 1'b0) begin bad++; $display("FAIL haz_rt edge=%0d got=%0b want=0", e, o_hazard_rt); end
      step();
    end
    total++; if (o_hazard_rs !== 1'b0) begin bad++; $display("FAIL haz_after_pop got=%0b want=0", o_hazard_rs); end
    // rd = 0 executes but never raises a hazard
    rs = 5'd0;
    drive_issue(32'd1, 32'd1, 1'b0, 5'd0);
    step();
    valid = 1'b0;
    for (int e = 0; e < 3; e++) begin
      total++; if (o_hazard_rs !== 1'b0 || o_hazard_rt !== 1'b0) begin bad++; $display("FAIL haz_r0 edge=%0d got=%0b%0b want=00", e, o_hazard_rs, o_hazard_rt); end
      step();
    end
    total++; if (o_wb_valid !== 1'b1 || o_wb_rd !== 5'd0 || o_wb_data !== 32'd1) begin
      bad++; $display("FAIL haz_r0_wb got=%0b/%0d/%0d want=1/0/1", o_wb_valid, o_wb_rd, o_wb_data);
    end
    step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_continuous();
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    logic [W-1:0]    pa;
    logic [W-1:0]    pb;
    logic [W-1:0]    pp;
    logic [RW+W-1:0] got;
    logic [RW+W-1:0] want;
    grant = 1'b1;
    exp_q.delete();
    while (recv < 20 && cyc < 300) begin
      if (o_wb_valid === 1'b1) begin
        got = {o_wb_rd, o_wb_data};
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL cont_unexpected got=%0h want=none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin bad++; $display("FAIL cont_result n=%0d got=%0h want=%0h", recv, got, want); end
        end
        recv++;
      end
      if (sent < 20) begin
        pa = 32'(sent * 3 + 1);
        pb = 32'(sent + 100);
        pp = pa * pb;
        drive_issue(pa, pb, sent[0], RW'((sent % 31) + 1));
        if (o_ready === 1'b1) begin
          exp_q.push_back({RW'((sent % 31) + 1), pp});
          sent++;
        end
      end else begin
        valid = 1'b0;
      end
      step();
      cyc++;
    end
    valid = 1'b0;
    total++; if (recv != 20) begin bad++; $display("FAIL cont_count got=%0d want=20", recv); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cont_leftover got=%0d want=0", exp_q.size()); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_issue(32'd2, 32'(i + 1), 1'b0, RW'(10 + i));
      step();
    end
    valid = 1'b0;
    step();                     // two in stages, two buffered
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre got=%0b want=1", o_busy); end
    rst = 1'b1;
    drive_issue(32'd3, 32'd3, 1'b0, 5'd7);  // must lose to reset
    grant = 1'b1;
    rs = 5'd12;
    step();
    rst = 1'b0; valid = 1'b0;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b want=0", o_busy); end
    total++; if (o_wb_valid !== 1'b0) begin bad++; $display("FAIL mid_wb_valid got=%0b want=0", o_wb_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%0b want=1", o_ready); end
    total++; if (o_hazard_rs !== 1'b0) begin bad++; $display("FAIL mid_hazard got=%0b want=0", o_hazard_rs); end
    for (int c = 0; c < 6; c++) begin
      step();
      total++; if (o_wb_valid !== 1'b0) begin bad++; $display("FAIL mid_stale c=%0d got=%0b/%0d want=0", c, o_wb_valid, o_wb_rd); end
    end
    rs = '0;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_signed(1'b1, 32'hFFFF_FFFF);
    test_signed(1'b0, 32'h0000_0001);
    test_back_to_back();
    test_hazard();
    test_continuous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
